// File: rtl/program_loader.sv
// rtl/program_loader.sv - UART-fed program loader and divided-clock core run controller
// Define LOADER_CHECKSUM_EN to add the checksum output (running byte sum of LOAD traffic).
module program_loader #(
  parameter int WORD_BYTES = 4,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 16384,
  parameter int DIV        = 50000000,
  parameter int TIMEOUT    = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    run,
  input  logic                    halt,
  output logic [ADDR_W-1:0]       pmem_addr,
  output logic [8*WORD_BYTES-1:0] pmem_data,
  output logic                    pmem_we,
  output logic                    core_reset,
  output logic                    core_tick,
  output logic [ADDR_W-1:0]       words_loaded,
  output logic                    error,
  output logic [1:0]              state
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [7:0]              checksum
`endif
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int BC_W  = $clog2(WORD_BYTES) + 1;
  localparam int PTR_W = ADDR_W + 1;
  localparam int DV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [BC_W-1:0]  LAST_LANE = BC_W'(WORD_BYTES - 1);
  localparam logic [DV_W-1:0]  DIV_LAST  = DV_W'(DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [PTR_W-1:0] FULL_PTR  = PTR_W'(DEPTH);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  state_t           st;
  logic [BC_W-1:0]  byte_cnt;
  logic [W-1:0]     word_buf;
  logic [W-1:0]     assembled;
  logic [PTR_W-1:0] word_ptr;
  logic [DV_W-1:0]  div_cnt;
  logic [DV_W-1:0]  div_next;
  logic [TO_W-1:0]  idle_cnt;
  logic             timed_out;

  assign state = st;

  // Word as it would look with the current byte dropped into its lane.
  always_comb begin
    assembled = word_buf;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (byte_cnt == BC_W'(i)) begin
        assembled[8*i +: 8] = rx_data;
      end
    end
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + DV_W'(1);
  end

  assign timed_out = (TIMEOUT != 0) && (idle_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= S_LOAD;
      byte_cnt     <= '0;
      word_buf     <= '0;
      word_ptr     <= '0;
      div_cnt      <= '0;
      idle_cnt     <= '0;
      pmem_addr    <= '0;
      pmem_data    <= '0;
      pmem_we      <= 1'b0;
      core_reset   <= 1'b1;
      core_tick    <= 1'b0;
      words_loaded <= '0;
      error        <= 1'b0;
    end else begin
      pmem_we <= 1'b0;
      case (st)
        S_LOAD: begin
          if (halt) begin
            byte_cnt     <= '0;
            word_ptr     <= '0;
            words_loaded <= '0;
            div_cnt      <= '0;
            idle_cnt     <= '0;
          end else if (rx_valid) begin
            idle_cnt <= '0;
            if (byte_cnt == LAST_LANE) begin
              byte_cnt <= '0;
              if (word_ptr == FULL_PTR) begin
                st    <= S_ABORT;
                error <= 1'b1;
              end else begin
                pmem_we      <= 1'b1;
                pmem_data    <= assembled;
                pmem_addr    <= ADDR_W'(word_ptr) * ADDR_W'(WORD_BYTES);
                word_ptr     <= word_ptr + PTR_W'(1);
                words_loaded <= words_loaded + ADDR_W'(1);
              end
            end else begin
              word_buf <= assembled;
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end else if (byte_cnt != '0) begin
            // A stalled partial word is dropped rather than padded.
            if (timed_out) begin
              st       <= S_ABORT;
              error    <= 1'b1;
              byte_cnt <= '0;
              idle_cnt <= '0;
            end else begin
              idle_cnt <= idle_cnt + TO_W'(1);
            end
          end else if (run) begin
            st         <= S_RUN;
            core_reset <= 1'b0;
            div_cnt    <= '0;
            core_tick  <= (DIV == 1);
          end
        end

        S_RUN: begin
          if (halt) begin
            st           <= S_LOAD;
            core_reset   <= 1'b1;
            core_tick    <= 1'b0;
            byte_cnt     <= '0;
            word_ptr     <= '0;
            words_loaded <= '0;
            div_cnt      <= '0;
            idle_cnt     <= '0;
          end else begin
            // Tick is registered, so it is decided from the counter's next value.
            div_cnt   <= div_next;
            core_tick <= (div_next == DIV_LAST);
          end
        end

        S_ABORT: begin
          if (halt) begin
            st           <= S_LOAD;
            error        <= 1'b0;
            byte_cnt     <= '0;
            word_ptr     <= '0;
            words_loaded <= '0;
            div_cnt      <= '0;
            idle_cnt     <= '0;
          end
        end

        default: begin
          st <= S_LOAD;
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || halt) begin
      checksum <= '0;
    end else if (st == S_LOAD && rx_valid) begin
      checksum <= checksum + rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader with a queue-based reference model
// Define LOADER_CHECKSUM_EN to also cover the checksum output.
module tb_program_loader;

  localparam int WB    = 4;
  localparam int AW    = 16;
  localparam int DEPTH = 2;
  localparam int DIV   = 4;
  localparam int TMO   = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          run = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] pmem_addr;
  logic [31:0]   pmem_data;
  logic          pmem_we;
  logic          core_reset;
  logic          core_tick;
  logic [AW-1:0] words_loaded;
  logic          error;
  logic [1:0]    state;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]    checksum;
`endif

  program_loader #(
    .WORD_BYTES(WB), .ADDR_W(AW), .DEPTH(DEPTH), .DIV(DIV), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .run(run), .halt(halt), .pmem_addr(pmem_addr), .pmem_data(pmem_data),
    .pmem_we(pmem_we), .core_reset(core_reset), .core_tick(core_tick),
    .words_loaded(words_loaded), .error(error), .state(state)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           exp_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  bit            mon_en = 0;
  logic [AW-1:0] last_addr = '0;
  logic [31:0]   last_data = '0;

  // Reference model: bytes queue up until a word is complete.
  int            m_state = 0;
  logic [7:0]    m_bytes[$];
  int            m_idle = 0;
  int            m_words = 0;
  int            m_run_cnt = 0;
  bit            m_error = 0;
  logic [7:0]    m_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_bytes.delete();
    m_idle = 0;
    m_words = 0;
    m_run_cnt = 0;
    m_sum = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit r, input bit h);
    wr_t w;
    case (m_state)
      0: begin
        if (h) begin
          model_clear();
        end else if (v) begin
          m_sum = m_sum + d;
          m_idle = 0;
          m_bytes.push_back(d);
          if (m_bytes.size() == WB) begin
            if (m_words == DEPTH) begin
              m_state = 2;
              m_error = 1;
            end else begin
              w.addr = AW'(m_words * WB);
              for (int i = 0; i < WB; i++) w.data[8*i +: 8] = m_bytes[i];
              exp_q.push_back(w);
              m_words++;
            end
            m_bytes.delete();
          end
        end else if (m_bytes.size() != 0) begin
          m_idle++;
          if (m_idle == TMO) begin
            m_state = 2;
            m_error = 1;
            m_bytes.delete();
            m_idle = 0;
          end
        end else if (r) begin
          m_state = 1;
          m_run_cnt = 1;
        end
      end
      1: begin
        if (h) begin
          m_state = 0;
          model_clear();
        end else begin
          m_run_cnt++;
        end
      end
      default: begin
        if (h) begin
          m_state = 0;
          m_error = 0;
          model_clear();
        end
      end
    endcase
  endtask

  task automatic check_outputs();
    chk("state", 64'(state), 64'(m_state));
    chk("core_reset", 64'(core_reset), 64'(m_state != 1));
    chk("error", 64'(error), 64'(m_error));
    chk("words_loaded", 64'(words_loaded), 64'(m_words));
    chk("core_tick", 64'(core_tick), 64'((m_state == 1) && (m_run_cnt % DIV == 0)));
`ifdef LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(m_sum));
`endif
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit r, input bit h);
    rx_valid = v;
    rx_data  = d;
    run      = r;
    halt     = h;
    @(posedge clk);
    model_step(v, d, r, h);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rx_valid = 1'b1;
    rx_data  = 8'($urandom);
    run      = 1'b1;
    halt     = 1'b1;
    reset    = 1'b1;
    @(posedge clk);
    m_state = 0;
    m_error = 0;
    model_clear();
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
    mon_en = 1;
    @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b0;
    run      = 1'b0;
    halt     = 1'b0;
    check_outputs();
  endtask

  // Monitor: every expected write must appear exactly in the cycle after its last byte.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pmem_we", 64'(pmem_we), 64'(1));
          chk("pmem_addr", 64'(pmem_addr), 64'(e.addr));
          chk("pmem_data", 64'(pmem_data), 64'(e.data));
          last_addr = e.addr;
          last_data = e.data;
        end else begin
          chk("pmem_we_idle", 64'(pmem_we), 64'(0));
          chk("pmem_addr_hold", 64'(pmem_addr), 64'(last_addr));
          chk("pmem_data_hold", 64'(pmem_data), 64'(last_data));
        end
      end
    end
  end

  initial begin
    int ticks;
    logic [7:0] t1 [8];
    t1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h12, 8'h34, 8'h56};

    do_reset();

    // Little-endian assembly of two words
    for (int i = 0; i < 8; i++) send_byte(t1[i]);
    chk("t1_addr", 64'(pmem_addr), 64'h4);
    chk("t1_data", 64'(pmem_data), 64'h563412B7);
    chk("t1_words", 64'(words_loaded), 64'd2);

    // Run with divided tick, then halt
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_state", 64'(state), 64'd1);
    chk("t2_core_reset", 64'(core_reset), 64'd0);
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      if (core_tick === 1'b1) ticks++;
    end
    chk("t2_ticks", 64'(ticks), 64'd3);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t2_halt_core_reset", 64'(core_reset), 64'd1);
    chk("t2_halt_words", 64'(words_loaded), 64'd0);

    // Partial word timeout
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    idle(TMO - 1);
    chk("t3_before_timeout", 64'(state), 64'd0);
    idle(1);
    chk("t3_timeout_state", 64'(state), 64'd2);
    chk("t3_timeout_error", 64'(error), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_halt_state", 64'(state), 64'd0);
    chk("t3_halt_error", 64'(error), 64'd0);

    // Overflow past DEPTH words
    do_reset();
    for (int i = 0; i < 12; i++) send_byte(8'($urandom));
    chk("t4_state", 64'(state), 64'd2);
    chk("t4_error", 64'(error), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Run gating, run+halt, reset mid-word
    send_byte(8'h01);
    send_byte(8'h02);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_run_partial", 64'(state), 64'd0);
    send_byte(8'h03);
    send_byte(8'h04);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    chk("t5_run_with_rx", 64'(state), 64'd0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_run", 64'(state), 64'd1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("t5_run_halt", 64'(state), 64'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    do_reset();
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    chk("t5_addr", 64'(pmem_addr), 64'h0);
    chk("t5_data", 64'(pmem_data), 64'hDDCCBBAA);

`ifdef LOADER_CHECKSUM_EN
    step(1'b0, 8'h00, 1'b0, 1'b1);
    send_byte(8'hFF);
    send_byte(8'h02);
    send_byte(8'h01);
    send_byte(8'h00);
    chk("t6_checksum", 64'(checksum), 64'h02);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("t6_checksum_halt", 64'(checksum), 64'h00);
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 3000; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       do_reset();
      else if (r < 5)  step(1'b0, 8'h00, 1'b0, 1'b1);
      else if (r < 12) step(1'b0, 8'h00, 1'b1, 1'b0);
      else if (r < 14) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      else if (r < 15) idle(TMO + 5);
      else if (r < 16) step(1'b0, 8'h00, 1'b1, 1'b1);
      else if (r < 60) send_byte(8'($urandom));
      else             idle(1);
    end

    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
